vend_dispenser: RTL



---
 rtl/vend_pkg.sv | 31 +++
 rtl/vend_timeout_ctr.sv | 27 ++
 rtl/vend_dispenser.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispenser: FSM states, product codes
// and the product-to-motor decode.
package vend_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOTOR,
    S_PAY_PULSE,
    S_PAY_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [1:0] PROD_A    = 2'b00;
  localparam logic [1:0] PROD_B    = 2'b01;
  localparam logic [1:0] PROD_C    = 2'b10;
  localparam logic [1:0] PROD_NONE = 2'b11;

  localparam int unsigned CHANGE_W = 3;

  // One-hot spiral motor select; PROD_NONE drives no motor.
  function automatic logic [2:0] prod_onehot(input logic [1:0] p);
    case (p)
      PROD_A:  return 3'b001;
      PROD_B:  return 3'b010;
      PROD_C:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Loadable down-counter with synchronous clear; expired_c flags a count of zero.
module vend_timeout_ctr #(
  parameter int unsigned W = 11
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired_c = (cnt == '0);

endmodule

// File: rtl/vend_dispenser.sv
// Vending output controller: drives the product spiral motor, then pays change one
// coin at a time through the hopper, reporting busy/done/fault/overrun.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned MOTOR_TIMEOUT  = 1000,
  parameter int unsigned HOPPER_TIMEOUT = 200,
  parameter int unsigned PULSE_LEN      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vend_valid,
  input  logic [1:0]          productout,
  input  logic [CHANGE_W-1:0] change,
  input  logic                motor_done,
  input  logic                hopper_ack,
  input  logic                fault_clr,
  output logic [2:0]          motor_en,
  output logic                coin_eject,
  output logic                busy,
  output logic                done,
  output logic                fault,
  output logic                overrun
);

  localparam int unsigned MAX_TO  = (MOTOR_TIMEOUT > HOPPER_TIMEOUT) ? MOTOR_TIMEOUT : HOPPER_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(MAX_TO) + 1;
  localparam int unsigned PULSE_W = $clog2(PULSE_LEN) + 1;

  state_t              state;
  logic [1:0]          prod;
  logic [CHANGE_W-1:0] coins;
  logic [PULSE_W-1:0]  pulse_cnt;

  logic             to_en_c;
  logic             to_load_c;
  logic [CNT_W-1:0] to_val_c;
  logic             to_expired_c;

  // The timer counts only in MOTOR/PAY_WAIT and is reloaded in every other state,
  // so each entry starts fresh; the reload value depends on which wait comes next.
  assign to_en_c   = (state == S_MOTOR) || (state == S_PAY_WAIT);
  assign to_load_c = !to_en_c;
  assign to_val_c  = (state == S_PAY_PULSE) ? CNT_W'(HOPPER_TIMEOUT - 1)
                                            : CNT_W'(MOTOR_TIMEOUT - 1);

  vend_timeout_ctr #(.W(CNT_W)) u_timeout (
    .clk       (clk),
    .clr       (rst),
    .load      (to_load_c),
    .en        (to_en_c),
    .load_val  (to_val_c),
    .expired_c (to_expired_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      prod       <= '0;
      coins      <= '0;
      pulse_cnt  <= '0;
      motor_en   <= '0;
      coin_eject <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done    <= 1'b0;
      overrun <= vend_valid && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (vend_valid) begin
            prod  <= productout;
            coins <= change;
            busy  <= 1'b1;
            if (productout != PROD_NONE) begin
              state    <= S_MOTOR;
              motor_en <= prod_onehot(productout);
            end else if (change != '0) begin
              state      <= S_PAY_PULSE;
              coin_eject <= 1'b1;
              pulse_cnt  <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_MOTOR: begin
          // motor_done takes priority over a simultaneous timeout
          if (motor_done) begin
            motor_en <= '0;
            if (coins != '0) begin
              state      <= S_PAY_PULSE;
              coin_eject <= 1'b1;
              pulse_cnt  <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end else if (to_expired_c) begin
            motor_en <= '0;
            state    <= S_FAULT;
            fault    <= 1'b1;
          end else begin
            motor_en <= prod_onehot(prod);
          end
        end
        S_PAY_PULSE: begin
          if (pulse_cnt == PULSE_W'(PULSE_LEN - 1)) begin
            coin_eject <= 1'b0;
            state      <= S_PAY_WAIT;
          end else begin
            pulse_cnt <= pulse_cnt + PULSE_W'(1);
          end
        end
        S_PAY_WAIT: begin
          if (hopper_ack) begin
            if (coins != '0) begin
              coins <= coins - CHANGE_W'(1);
            end
            if (coins <= CHANGE_W'(1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_PAY_PULSE;
              coin_eject <= 1'b1;
              pulse_cnt  <= '0;
            end
          end else if (to_expired_c) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_FAULT: begin
          if (fault_clr) begin
            state <= S_IDLE;
            fault <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
